ksa_sub_pipe: RTL and testbench

//  Pipelined Kogge-Stone subtractor: computes d = a - b - bin using a radix-2 parallel-prefix

---
 rtl/ksa_sub_pipe.sv | 112 +++++++++++
 tb/tb_ksa_sub_pipe.sv | 272 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/ksa_sub_pipe.sv
// Pipelined Kogge-Stone subtractor: d = a - b - bin as a + ~b + ~bin, one prefix level per stage.
// Define KSA_SUB_OVF_EN to add the signed-overflow output v.
module ksa_sub_pipe #(
    parameter int unsigned WIDTH = 4,
    parameter int unsigned LOG2W = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             bin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] d,
    output logic             bout,
    output logic [WIDTH-1:0] c
`ifdef KSA_SUB_OVF_EN
    ,
    output logic             v
`endif
);
    // Stage 0 plus one stage per prefix level
    localparam int NSTG = int'(LOG2W) + 1;

    logic                       adv;
    logic [NSTG-1:0]            vld_q;
    logic [NSTG-1:0]            cin_q;
    logic [NSTG-1:0][WIDTH-1:0] gen_q;
    logic [NSTG-1:0][WIDTH-1:0] prp_q;
    logic [NSTG-1:0][WIDTH-1:0] p0_q;
    logic [NSTG-1:0][WIDTH-1:0] gen_d;
    logic [NSTG-1:0][WIDTH-1:0] prp_d;
    logic [WIDTH-1:0]           carry;
    logic [WIDTH-1:0]           diff;

    // Single global stall: everything moves together or nothing moves
    assign adv      = ~out_valid | out_ready;
    assign in_ready = adv;

    assign gen_d[0] = a & ~b;
    assign prp_d[0] = a ^ ~b;

    // Prefix level k combines each bit with its partner 2^(k-1) positions lower
    for (genvar k = 1; k < NSTG; k++) begin : g_lvl
        localparam int DIST = 1 << (k - 1);
        for (genvar i = 0; i < int'(WIDTH); i++) begin : g_bit
            if (i >= DIST) begin : g_merge
                assign gen_d[k][i] = gen_q[k-1][i] | (prp_q[k-1][i] & gen_q[k-1][i-DIST]);
                assign prp_d[k][i] = prp_q[k-1][i] & prp_q[k-1][i-DIST];
            end else begin : g_pass
                assign gen_d[k][i] = gen_q[k-1][i];
                assign prp_d[k][i] = prp_q[k-1][i];
            end
        end
    end

    // Tree and side-band pipeline; p0 and cin ride along to the final stage
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vld_q <= '0;
            cin_q <= '0;
            gen_q <= '0;
            prp_q <= '0;
            p0_q  <= '0;
        end else if (adv) begin
            vld_q <= {vld_q[NSTG-2:0], in_valid};
            cin_q <= {cin_q[NSTG-2:0], ~bin};
            gen_q <= gen_d;
            prp_q <= prp_d;
            p0_q  <= {p0_q[NSTG-2:0], a ^ ~b};
        end
    end

    // Group terms span bits 0..i, so the carry-in folds in through the group propagate
    assign carry = gen_q[NSTG-1] | (prp_q[NSTG-1] & {WIDTH{cin_q[NSTG-1]}});
    assign diff  = p0_q[NSTG-1] ^ {carry[WIDTH-2:0], cin_q[NSTG-1]};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid <= 1'b0;
            d         <= '0;
            c         <= '0;
            bout      <= 1'b0;
        end else if (adv) begin
            out_valid <= vld_q[NSTG-1];
            d         <= diff;
            c         <= carry;
            bout      <= ~carry[WIDTH-1];
        end
    end

`ifdef KSA_SUB_OVF_EN
    logic [NSTG-1:0] amsb_q;
    logic [NSTG-1:0] bmsb_q;

    // Operand sign bits travel with the data for the overflow term
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            amsb_q <= '0;
            bmsb_q <= '0;
            v      <= 1'b0;
        end else if (adv) begin
            amsb_q <= {amsb_q[NSTG-2:0], a[WIDTH-1]};
            bmsb_q <= {bmsb_q[NSTG-2:0], b[WIDTH-1]};
            v      <= (amsb_q[NSTG-1] ^ bmsb_q[NSTG-1]) & (diff[WIDTH-1] ^ amsb_q[NSTG-1]);
        end
    end
`endif

endmodule

// File: tb/tb_ksa_sub_pipe.sv
// Bench for ksa_sub_pipe (WIDTH=4): directed steps, scoreboard of model results, stall and reset cases.
module tb_ksa_sub_pipe;
    localparam int unsigned W = 4;

    typedef struct packed {
        logic [W-1:0] d;
        logic [W-1:0] c;
        logic         bout;
        logic         v;
    } exp_t;

    logic         clk = 1'b0;
    logic         rst;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         bin;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] d;
    logic         bout;
    logic [W-1:0] c;
`ifdef KSA_SUB_OVF_EN
    logic         v;
`endif

    int   checks   = 0;
    int   failures = 0;
    exp_t exp_q[$];

    ksa_sub_pipe #(.WIDTH(W), .LOG2W(2)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .bin       (bin),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .d         (d),
        .bout      (bout),
        .c         (c)
`ifdef KSA_SUB_OVF_EN
        ,
        .v         (v)
`endif
    );

    always #5 clk = ~clk;

    // Reference: plain integer sums, carry of bit i from the sum of bits 0..i
    function automatic exp_t model(input logic [W-1:0] a_i, input logic [W-1:0] b_i,
                                   input logic bin_i);
        exp_t       e;
        logic [W:0] s;
        logic [W:0] msk;
        logic [W-1:0] nb;
        logic       ci;
        nb = ~b_i;
        ci = ~bin_i;
        s = {1'b0, a_i} + {1'b0, nb} + (W+1)'(ci);
        e.d    = s[W-1:0];
        e.bout = ~s[W];
        e.c    = '0;
        for (int i = 0; i < int'(W); i++) begin
            msk = (W+1)'((1 << (i + 1)) - 1);
            s = ({1'b0, a_i} & msk) + ({1'b0, nb} & msk) + (W+1)'(ci);
            e.c[i] = s[i+1];
        end
        e.v = (a_i[W-1] ^ b_i[W-1]) & (e.d[W-1] ^ a_i[W-1]);
        return e;
    endfunction

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] expv);
        checks++;
        assert (obs === expv) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    // One clock: drive, score any output transfer, record any input transfer, advance
    task automatic cyc(input logic iv, input logic [W-1:0] ai, input logic [W-1:0] bi,
                       input logic bini, input logic ordy, output logic acc);
        exp_t e;
        in_valid  = iv;
        a         = ai;
        b         = bi;
        bin       = bini;
        out_ready = ordy;
        #1;
        if (out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
                chk("spurious_result", 8'(out_valid), 8'd0);
            end else begin
                e = exp_q.pop_front();
                chk("sb_d", 8'(d), 8'(e.d));
                chk("sb_c", 8'(c), 8'(e.c));
                chk("sb_bout", 8'(bout), 8'(e.bout));
`ifdef KSA_SUB_OVF_EN
                chk("sb_v", 8'(v), 8'(e.v));
`endif
            end
        end
        acc = in_valid && in_ready;
        if (acc) exp_q.push_back(model(ai, bi, bini));
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        logic acc;
        cyc(1'b0, '0, '0, 1'b0, 1'b1, acc);
    endtask

    task automatic drain();
        int n;
        n = 0;
        while ((exp_q.size() != 0 || out_valid) && n < 40) begin
            idle();
            n++;
        end
        chk("drain_empty", 8'(exp_q.size()), 8'd0);
        chk("drain_idle", 8'(out_valid), 8'd0);
    endtask

    initial begin
        logic         acc;
        logic         pend;
        logic [W-1:0] ra;
        logic [W-1:0] rb;
        logic         rbin;

        rst = 1'b1; in_valid = 1'b0; a = '0; b = '0; bin = 1'b0; out_ready = 1'b1;
        @(posedge clk);
        #1;
        chk("rst_out_valid", 8'(out_valid), 8'd0);
        chk("rst_in_ready", 8'(in_ready), 8'd1);
        chk("rst_d", 8'(d), 8'd0);
        chk("rst_c", 8'(c), 8'd0);
        chk("rst_bout", 8'(bout), 8'd0);
        rst = 1'b0;
        @(posedge clk);
        #1;

        // Directed vector 1 with exact latency
        cyc(1'b1, 4'b1001, 4'b1100, 1'b0, 1'b1, acc);
        chk("t1_acc", 8'(acc), 8'd1);
        chk("t1_lat1", 8'(out_valid), 8'd0);
        idle();
        chk("t1_lat2", 8'(out_valid), 8'd0);
        idle();
        chk("t1_lat3", 8'(out_valid), 8'd0);
        idle();
        chk("t1_lat4", 8'(out_valid), 8'd1);
        chk("t1_d", 8'(d), 8'b1101);
        chk("t1_c", 8'(c), 8'b0011);
        chk("t1_bout", 8'(bout), 8'd1);
        drain();

        // Directed pair, including borrow-in
        cyc(1'b1, 4'b1111, 4'b1101, 1'b0, 1'b1, acc);
        cyc(1'b1, 4'b0001, 4'b1110, 1'b1, 1'b1, acc);
        idle();
        idle();
        chk("t2a_d", 8'(d), 8'b0010);
        chk("t2a_c", 8'(c), 8'b1111);
        chk("t2a_bout", 8'(bout), 8'd0);
        idle();
        chk("t2b_d", 8'(d), 8'b0010);
        chk("t2b_c", 8'(c), 8'b0001);
        chk("t2b_bout", 8'(bout), 8'd1);
        drain();

        // a == b, no borrow: zero difference, carries all ones
        cyc(1'b1, 4'b0110, 4'b0110, 1'b0, 1'b1, acc);
        repeat (3) idle();
        chk("eq_d", 8'(d), 8'd0);
        chk("eq_c", 8'(c), 8'b1111);
        chk("eq_bout", 8'(bout), 8'd0);
        drain();

        // Back-to-back: four results on consecutive clocks
        for (int i = 0; i < 4; i++) begin
            cyc(1'b1, 4'($urandom), 4'($urandom), 1'($urandom), 1'b1, acc);
            chk("b2b_acc", 8'(acc), 8'd1);
        end
        chk("b2b_first", 8'(out_valid), 8'd1);
        for (int i = 0; i < 3; i++) begin
            idle();
            chk("b2b_nogap", 8'(out_valid), 8'd1);
        end
        drain();

        // Full pipe stalled three clocks; offered input must be refused
        for (int i = 0; i < 4; i++) cyc(1'b1, 4'($urandom), 4'($urandom), 1'($urandom), 1'b1, acc);
        for (int i = 0; i < 3; i++) begin
            cyc(1'b1, 4'($urandom), 4'($urandom), 1'($urandom), 1'b0, acc);
            chk("stall_refused", 8'(acc), 8'd0);
            chk("stall_in_ready", 8'(in_ready), 8'd0);
            chk("stall_valid", 8'(out_valid), 8'd1);
            chk("stall_d", 8'(d), 8'(exp_q[0].d));
            chk("stall_c", 8'(c), 8'(exp_q[0].c));
            chk("stall_bout", 8'(bout), 8'(exp_q[0].bout));
        end
        chk("stall_pending", 8'(exp_q.size()), 8'd4);
        drain();

        // Reset mid-stream with one result at the output and three in flight
        cyc(1'b1, 4'b1001, 4'b1100, 1'b0, 1'b1, acc);
        for (int i = 0; i < 3; i++) cyc(1'b1, 4'($urandom), 4'($urandom), 1'($urandom), 1'b0, acc);
        rst = 1'b1;
        #1;
        chk("mid_rst_valid", 8'(out_valid), 8'd0);
        chk("mid_rst_d", 8'(d), 8'd0);
        chk("mid_rst_c", 8'(c), 8'd0);
        chk("mid_rst_bout", 8'(bout), 8'd0);
        chk("mid_rst_in_ready", 8'(in_ready), 8'd1);
        exp_q.delete();
        in_valid = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b0;
        chk("post_rst_valid", 8'(out_valid), 8'd0);
        cyc(1'b1, 4'b0110, 4'b0011, 1'b0, 1'b1, acc);
        chk("alone_lat1", 8'(out_valid), 8'd0);
        idle();
        chk("alone_lat2", 8'(out_valid), 8'd0);
        idle();
        chk("alone_lat3", 8'(out_valid), 8'd0);
        idle();
        chk("alone_lat4", 8'(out_valid), 8'd1);
        chk("alone_d", 8'(d), 8'b0011);
        idle();
        chk("alone_only", 8'(out_valid), 8'd0);
        drain();

`ifdef KSA_SUB_OVF_EN
        // Signed overflow
        cyc(1'b1, 4'b0111, 4'b1000, 1'b0, 1'b1, acc);
        cyc(1'b1, 4'b0011, 4'b0001, 1'b0, 1'b1, acc);
        idle();
        idle();
        chk("ovf_d", 8'(d), 8'b1111);
        chk("ovf_bout", 8'(bout), 8'd1);
        chk("ovf_v", 8'(v), 8'd1);
        idle();
        chk("noovf_d", 8'(d), 8'b0010);
        chk("noovf_v", 8'(v), 8'd0);
        drain();
`endif

        // Random traffic with random backpressure; source holds a refused vector
        pend = 1'b0; ra = '0; rb = '0; rbin = 1'b0;
        for (int i = 0; i < 80; i++) begin
            if (!pend) begin
                pend = ($urandom_range(0, 3) != 0);
                ra   = 4'($urandom);
                rb   = 4'($urandom);
                rbin = 1'($urandom);
            end
            cyc(pend, ra, rb, rbin, ($urandom_range(0, 2) != 0), acc);
            if (acc) pend = 1'b0;
        end
        drain();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
